// File: rtl/multi_cycle_controller.sv
// Main control FSM of the multi-cycle MIPS CPU: steps each instruction through IF/ID/EX/MEM/WB and drives datapath controls.
// Latency: outputs are a combinational decode of the current state. lw takes 5 cycles; sw/R/I take 4; beq/j/jal/jr/jalr take 3.
// Backpressure: none. The FSM advances every cycle. Optional macro ILLEGAL_TRAP_EN sends undecoded instructions to an absorbing TRAP state.
module multi_cycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OpCode,
  input  logic [5:0] Funct,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       ExtOp,
  output logic       LuiOp,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [3:0] ALUOp,
  output logic       Illegal
);

  typedef enum logic [3:0] {
    S_INIT  = 4'd0,
    S_IF    = 4'd1,
    S_ID    = 4'd2,
    S_MADDR = 4'd3,
    S_MRD   = 4'd4,
    S_LWB   = 4'd5,
    S_MWR   = 4'd6,
    S_REX   = 4'd7,
    S_RWB   = 4'd8,
    S_IEX   = 4'd9,
    S_IWB   = 4'd10,
    S_BR    = 4'd11,
    S_JMP   = 4'd12,
    S_JR    = 4'd13,
    S_TRAP  = 4'd14
  } state_t;

  // ALU operation class codes (low three bits of ALUOp)
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  // Funct codes
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;

  state_t state_q, state_d;

  // Instruction-class decode. These are only meaningful from ID onward,
  // once the instruction register has been loaded.
  logic is_mem, is_rtype, is_jr_fn, is_beq, is_jump, is_imm;
  logic is_shift_imm, is_andi, is_lui;

  assign is_mem       = (OpCode == OP_LW) || (OpCode == OP_SW);
  assign is_rtype     = (OpCode == OP_RTYPE);
  assign is_jr_fn     = (Funct == FN_JR) || (Funct == FN_JALR);
  assign is_beq       = (OpCode == OP_BEQ);
  assign is_jump      = (OpCode == OP_J) || (OpCode == OP_JAL);
  assign is_imm       = (OpCode == OP_ADDI)  || (OpCode == OP_ADDIU) ||
                        (OpCode == OP_SLTI)  || (OpCode == OP_SLTIU) ||
                        (OpCode == OP_ANDI)  || (OpCode == OP_LUI);
  assign is_shift_imm = (Funct == FN_SLL) || (Funct == FN_SRL) || (Funct == FN_SRA);
  assign is_andi      = (OpCode == OP_ANDI);
  assign is_lui       = (OpCode == OP_LUI);

  // State register; asynchronous reset aborts any instruction in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state sequencing and ID dispatch
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT: state_d = S_IF;
      S_IF:   state_d = S_ID;
      S_ID: begin
        if (is_mem) begin
          state_d = S_MADDR;
        end else if (is_rtype) begin
          state_d = is_jr_fn ? S_JR : S_REX;
        end else if (is_beq) begin
          state_d = S_BR;
        end else if (is_jump) begin
          state_d = S_JMP;
        end else if (is_imm) begin
          state_d = S_IEX;
        end else begin
`ifdef ILLEGAL_TRAP_EN
          state_d = S_TRAP;
`else
          // PC was already advanced in IF, so this acts as a NOP
          state_d = S_IF;
`endif
        end
      end
      S_MADDR: state_d = (OpCode == OP_LW) ? S_MRD : S_MWR;
      S_MRD:   state_d = S_LWB;
      S_LWB:   state_d = S_IF;
      S_MWR:   state_d = S_IF;
      S_REX:   state_d = S_RWB;
      S_RWB:   state_d = S_IF;
      S_IEX:   state_d = S_IWB;
      S_IWB:   state_d = S_IF;
      S_BR:    state_d = S_IF;
      S_JMP:   state_d = S_IF;
      S_JR:    state_d = S_IF;
`ifdef ILLEGAL_TRAP_EN
      S_TRAP:  state_d = S_TRAP;
`endif
      default: state_d = S_INIT;
    endcase
  end

  // Datapath control decode; anything not set for a state stays 0
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    ExtOp       = 1'b0;
    LuiOp       = 1'b0;
    RegDst      = 2'b00;
    MemtoReg    = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    PCSource    = 2'b00;
    ALUOp       = 4'b0000;
    Illegal     = 1'b0;
    case (state_q)
      S_IF: begin
        // Fetch and PC+4 in one go
        MemRead  = 1'b1;
        IRWrite  = 1'b1;
        PCWrite  = 1'b1;
        ALUSrcA  = 2'b00;
        ALUSrcB  = 2'b01;
        ALUOp    = {1'b0, ALU_ADD};
        PCSource = 2'b00;
      end
      S_ID: begin
        // Speculative branch target into ALUOut
        ALUSrcA = 2'b00;
        ALUSrcB = 2'b11;
        ExtOp   = 1'b1;
        ALUOp   = {1'b0, ALU_ADD};
      end
      S_MADDR: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        ExtOp   = 1'b1;
        ALUOp   = {1'b0, ALU_ADD};
      end
      S_MRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_LWB: begin
        RegWrite = 1'b1;
        RegDst   = 2'b00;
        MemtoReg = 2'b01;
      end
      S_MWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_REX: begin
        // Immediate shifts take shamt on the A port
        ALUSrcA = is_shift_imm ? 2'b10 : 2'b01;
        ALUSrcB = 2'b00;
        ALUOp   = {1'b0, ALU_FUNCT};
      end
      S_RWB: begin
        RegWrite = 1'b1;
        RegDst   = 2'b01;
        MemtoReg = 2'b00;
      end
      S_IEX: begin
        ALUSrcA  = 2'b01;
        ALUSrcB  = 2'b10;
        ExtOp    = !is_andi;
        LuiOp    = is_lui;
        // OpCode[0] tells the ALU-control decoder signed vs unsigned
        ALUOp[3] = OpCode[0];
        case (OpCode)
          OP_SLTI, OP_SLTIU: ALUOp[2:0] = ALU_SLT;
          OP_ANDI:           ALUOp[2:0] = ALU_AND;
          default:           ALUOp[2:0] = ALU_ADD;
        endcase
      end
      S_IWB: begin
        RegWrite = 1'b1;
        RegDst   = 2'b00;
        MemtoReg = 2'b00;
      end
      S_BR: begin
        ALUSrcA     = 2'b01;
        ALUSrcB     = 2'b00;
        ALUOp       = {1'b0, ALU_SUB};
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      S_JMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        if (OpCode == OP_JAL) begin
          RegWrite = 1'b1;
          RegDst   = 2'b10;
          MemtoReg = 2'b10;
        end
      end
      S_JR: begin
        PCWrite  = 1'b1;
        PCSource = 2'b11;
        if (Funct == FN_JALR) begin
          RegWrite = 1'b1;
          RegDst   = 2'b01;
          MemtoReg = 2'b10;
        end
      end
`ifdef ILLEGAL_TRAP_EN
      S_TRAP: begin
        Illegal = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Directed bench for multi_cycle_controller: walks instruction classes through the FSM and checks every state's controls.
// Inputs change and outputs are sampled on the falling clock edge.
// Expected control words are hand-derived constants.
module tb_multi_cycle_controller;

  logic       clk;
  logic       reset;
  logic [5:0] OpCode;
  logic [5:0] Funct;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, ExtOp, LuiOp;
  logic [1:0] RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource;
  logic [3:0] ALUOp;
  logic       Illegal;

  int errors = 0;
  int checks = 0;

  multi_cycle_controller dut (
    .clk(clk), .reset(reset), .OpCode(OpCode), .Funct(Funct),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .ExtOp(ExtOp),
    .LuiOp(LuiOp), .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .PCSource(PCSource), .ALUOp(ALUOp), .Illegal(Illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control word: {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,RegWrite,ExtOp,LuiOp,
  //                RegDst,MemtoReg,ALUSrcA,ALUSrcB,PCSource,ALUOp,Illegal}
  logic [23:0] obs;
  assign obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, ExtOp, LuiOp,
                RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource, ALUOp, Illegal};

  localparam logic [23:0] E_ZERO   = 24'h000000;
  localparam logic [23:0] E_IF     = {9'b100101000, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 4'b0000, 1'b0};
  localparam logic [23:0] E_ID     = {9'b000000010, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 4'b0000, 1'b0};
  localparam logic [23:0] E_MADDR  = {9'b000000010, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 4'b0000, 1'b0};
  localparam logic [23:0] E_MRD    = {9'b001100000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 1'b0};
  localparam logic [23:0] E_LWB    = {9'b000000100, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 4'b0000, 1'b0};
  localparam logic [23:0] E_MWR    = {9'b001010000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 1'b0};
  localparam logic [23:0] E_REXSH  = {9'b000000000, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 4'b0010, 1'b0};
  localparam logic [23:0] E_REXRR  = {9'b000000000, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 4'b0010, 1'b0};
  localparam logic [23:0] E_RWB    = {9'b000000100, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 1'b0};
  localparam logic [23:0] E_SLTIU  = {9'b000000010, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 4'b1101, 1'b0};
  localparam logic [23:0] E_ANDI   = {9'b000000000, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 4'b0100, 1'b0};
  localparam logic [23:0] E_LUI    = {9'b000000011, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 4'b1000, 1'b0};
  localparam logic [23:0] E_IWB    = {9'b000000100, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 1'b0};
  localparam logic [23:0] E_BR     = {9'b010000000, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 4'b0001, 1'b0};
  localparam logic [23:0] E_JAL    = {9'b100000100, 2'b10, 2'b10, 2'b00, 2'b00, 2'b10, 4'b0000, 1'b0};
  localparam logic [23:0] E_J      = {9'b100000000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 4'b0000, 1'b0};
  localparam logic [23:0] E_JALR   = {9'b100000100, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11, 4'b0000, 1'b0};
  localparam logic [23:0] E_JR     = {9'b100000000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 4'b0000, 1'b0};
  localparam logic [23:0] E_TRAP   = 24'h000001;

  task automatic chk(input string tag, input logic [23:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, then compare at the falling edge
  task automatic nxt(input string tag, input logic [23:0] exp);
    @(negedge clk);
    chk(tag, exp);
  endtask

  // Pulse reset asynchronously, then check INIT and the first IF
  task automatic do_reset(input string tag);
    #1 reset = 1'b0;
    #1 chk({tag, "_async0"}, E_ZERO);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk({tag, "_init"}, E_ZERO);
    nxt({tag, "_if"}, E_IF);
  endtask

  initial begin
    reset  = 1'b0;
    OpCode = 6'h00;
    Funct  = 6'h00;
    #2 chk("reset_low", E_ZERO);
    @(negedge clk);
    chk("reset_held", E_ZERO);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("init", E_ZERO);
    nxt("first_if", E_IF);

    // lw: IF ID MADDR MRD LWB, IF again on cycle 6
    OpCode = 6'h23;
    nxt("lw_id", E_ID);
    nxt("lw_maddr", E_MADDR);
    nxt("lw_mrd", E_MRD);
    nxt("lw_lwb", E_LWB);
    nxt("lw_if", E_IF);

    // sw
    OpCode = 6'h2b;
    nxt("sw_id", E_ID);
    nxt("sw_maddr", E_MADDR);
    nxt("sw_mwr", E_MWR);
    nxt("sw_if", E_IF);

    // sra: shamt on A port
    OpCode = 6'h00; Funct = 6'h03;
    nxt("sra_id", E_ID);
    nxt("sra_rex", E_REXSH);
    nxt("sra_rwb", E_RWB);
    nxt("sra_if", E_IF);

    // addu: register A port
    Funct = 6'h21;
    nxt("addu_id", E_ID);
    nxt("addu_rex", E_REXRR);
    nxt("addu_rwb", E_RWB);
    nxt("addu_if", E_IF);

    // sltiu
    OpCode = 6'h0b; Funct = 6'h00;
    nxt("sltiu_id", E_ID);
    nxt("sltiu_iex", E_SLTIU);
    nxt("sltiu_iwb", E_IWB);
    nxt("sltiu_if", E_IF);

    // andi: zero-extend
    OpCode = 6'h0c;
    nxt("andi_id", E_ID);
    nxt("andi_iex", E_ANDI);
    nxt("andi_iwb", E_IWB);
    nxt("andi_if", E_IF);

    // lui
    OpCode = 6'h0f;
    nxt("lui_id", E_ID);
    nxt("lui_iex", E_LUI);
    nxt("lui_iwb", E_IWB);
    nxt("lui_if", E_IF);

    // beq: 3 cycles
    OpCode = 6'h04;
    nxt("beq_id", E_ID);
    nxt("beq_br", E_BR);
    nxt("beq_if", E_IF);

    // jal
    OpCode = 6'h03;
    nxt("jal_id", E_ID);
    nxt("jal_jmp", E_JAL);
    nxt("jal_if", E_IF);

    // j
    OpCode = 6'h02;
    nxt("j_id", E_ID);
    nxt("j_jmp", E_J);
    nxt("j_if", E_IF);

    // jalr
    OpCode = 6'h00; Funct = 6'h09;
    nxt("jalr_id", E_ID);
    nxt("jalr_jr", E_JALR);
    nxt("jalr_if", E_IF);

    // jr
    Funct = 6'h08;
    nxt("jr_id", E_ID);
    nxt("jr_jr", E_JR);
    nxt("jr_if", E_IF);

    // Undecoded opcode 0x3f
    OpCode = 6'h3f; Funct = 6'h00;
    nxt("ill_id", E_ID);
`ifdef ILLEGAL_TRAP_EN
    nxt("ill_trap", E_TRAP);
    nxt("ill_trap_hold1", E_TRAP);
    nxt("ill_trap_hold2", E_TRAP);
`else
    nxt("ill_nop_if", E_IF);
`endif
    do_reset("rst_after_ill");

    // Reset pulsed while in MRD: outputs drop in the same cycle
    OpCode = 6'h23;
    nxt("lw2_id", E_ID);
    nxt("lw2_maddr", E_MADDR);
    nxt("lw2_mrd", E_MRD);
    do_reset("rst_in_mrd");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
